// File: rtl/add_sub_8.sv
// Registered 8-bit two's-complement adder/subtractor with exact WIDTH+1 result and raw carry-out.
// Optional registered signed-overflow flag oOvf when ADD_SUB_OVF_FLAG_EN is defined.
module add_sub_8 #(
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iSA,
    input  logic [WIDTH-1:0] iData_a,
    input  logic [WIDTH-1:0] iData_b,
    output logic [WIDTH:0]   oData,
    output logic             oData_C
`ifdef ADD_SUB_OVF_FLAG_EN
    ,
    output logic             oOvf
`endif
);

    logic [WIDTH-1:0] b_cond;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;
    logic             msb_ext;

    // Ripple chain; subtract is a + ~b + 1 via carry-in.
    always_comb begin
        b_cond   = iSA ? ~iData_b : iData_b;
        carry    = '0;
        sum      = '0;
        carry[0] = iSA;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum[i]     = iData_a[i] ^ b_cond[i] ^ carry[i];
            carry[i+1] = (iData_a[i] & b_cond[i]) | (carry[i] & (iData_a[i] ^ b_cond[i]));
        end
        // Extra result bit is the sum bit of the sign-extended operands.
        msb_ext = iData_a[WIDTH-1] ^ b_cond[WIDTH-1] ^ carry[WIDTH];
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oData   <= '0;
            oData_C <= 1'b0;
        end else begin
            oData   <= {msb_ext, sum};
            oData_C <= carry[WIDTH];
        end
    end

`ifdef ADD_SUB_OVF_FLAG_EN
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oOvf <= 1'b0;
        end else begin
            oOvf <= carry[WIDTH] ^ carry[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_add_sub_8.sv
// Self-checking bench for add_sub_8 using a scoreboard queue of expected results.
// Covers reset, add/sub patterns, boundary cases, async reset and a random sweep.
module tb_add_sub_8;

    typedef struct packed {
        logic [8:0] data;
        logic       c;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       sa;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] data;
    logic       data_c;
`ifdef ADD_SUB_OVF_FLAG_EN
    logic       ovf;
`endif

    int   checks;
    int   failures;
    exp_t sb[$];

    add_sub_8 #(.WIDTH(8)) dut (
        .iClk    (clk),
        .iRst_n  (rst_n),
        .iSA     (sa),
        .iData_a (a),
        .iData_b (b),
        .oData   (data),
        .oData_C (data_c)
`ifdef ADD_SUB_OVF_FLAG_EN
        ,
        .oOvf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic s, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int   r;
        r = s ? ($signed(x) - $signed(y)) : ($signed(x) + $signed(y));
        e.data = r[8:0];
        if (s) e.c = (x >= y);
        else   e.c = (({1'b0, x} + {1'b0, y}) > 9'd255);
        e.ovf = (r > 127) || (r < -128);
        return e;
    endfunction

    task automatic drive(input logic s, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        sa = s;
        a  = x;
        b  = y;
        sb.push_back(model(s, x, y));
    endtask

    function automatic logic ovf_bad(input logic want);
`ifdef ADD_SUB_OVF_FLAG_EN
        return ovf !== want;
`else
        return 1'b0;
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sa = 1'($urandom);
            a  = 8'($urandom);
            b  = 8'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if (data !== 9'h000 || data_c !== 1'b0 || ovf_bad(1'b0)) begin
                failures++;
                $display("FAIL reset_hold: data=%h c=%b required data=000 c=0", data, data_c);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (data !== 9'h000 || data_c !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: data=%h c=%b required data=000 c=0", data, data_c);
        end
    endtask

    // Each row: {sa, a, b, expected data, expected c}; expected values from hand arithmetic.
    task automatic test_vectors(input string name, input logic [26:0] rows[], input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            drive(rows[i][26], rows[i][25:18], rows[i][17:10]);
            @(posedge clk);
            #1;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL %s_empty: scoreboard empty at row %0d", name, i);
            end else begin
                e = sb.pop_front();
                if (data !== e.data || data_c !== e.c || ovf_bad(e.ovf)
                    || data !== rows[i][9:1] || data_c !== rows[i][0]) begin
                    failures++;
                    $display("FAIL %s[%0d]: data=%h c=%b required data=%h c=%b",
                             name, i, data, data_c, rows[i][9:1], rows[i][0]);
                end
            end
        end
    endtask

    task automatic test_add();
        logic [26:0] rows[] = '{
            {1'b0, 8'h04, 8'h06, 9'h00A, 1'b0},
            {1'b0, 8'h84, 8'h80, 9'h104, 1'b1},
            {1'b0, 8'h80, 8'h80, 9'h100, 1'b1},
            {1'b0, 8'h7F, 8'h01, 9'h080, 1'b0}
        };
        test_vectors("add", rows, 4);
    endtask

    task automatic test_sub();
        logic [26:0] rows[] = '{
            {1'b1, 8'h41, 8'h42, 9'h1FF, 1'b0},
            {1'b1, 8'hC1, 8'hA1, 9'h020, 1'b1},
            {1'b1, 8'h82, 8'h01, 9'h181, 1'b1},
            {1'b1, 8'h40, 8'h81, 9'h0BF, 1'b0},
            {1'b1, 8'h7F, 8'hFF, 9'h080, 1'b0},
            {1'b1, 8'h80, 8'h80, 9'h000, 1'b1},
            {1'b1, 8'h7F, 8'h80, 9'h0FF, 1'b0}
        };
        test_vectors("sub", rows, 7);
    endtask

    task automatic test_async_reset();
        exp_t e;
        drive(1'b0, 8'h7F, 8'h01);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (data !== e.data || data_c !== e.c) begin
            failures++;
            $display("FAIL async_pre: data=%h c=%b required data=%h c=%b", data, data_c, e.data, e.c);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (data !== 9'h000 || data_c !== 1'b0 || ovf_bad(1'b0)) begin
            failures++;
            $display("FAIL async_immediate: data=%h c=%b required data=000 c=0", data, data_c);
        end
        @(negedge clk);
        sa = 1'b0;
        a  = 8'h80;
        b  = 8'h80;
        @(posedge clk);
        #1;
        checks++;
        if (data !== 9'h000 || data_c !== 1'b0) begin
            failures++;
            $display("FAIL async_discard: data=%h c=%b required data=000 c=0", data, data_c);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   bad = 0;
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom), 8'($urandom), 8'($urandom));
            @(posedge clk);
            #1;
            checks++;
            e = sb.pop_front();
            if (data !== e.data || data_c !== e.c || ovf_bad(e.ovf)) begin
                failures++;
                bad++;
                if (bad <= 20)
                    $display("FAIL random[%0d]: sa=%b a=%h b=%h data=%h c=%b required data=%h c=%b",
                             i, sa, a, b, data, data_c, e.data, e.c);
            end
        end
    endtask

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        sa       = 1'b0;
        a        = '0;
        b        = '0;
        checks   = 0;
        failures = 0;
        test_reset();
        test_add();
        test_sub();
        test_async_reset();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
